// File: rtl/if_fetch_pkg.sv
// Shared widths, reset/pause levels, NOP encoding and fetch state encoding
// for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned INST_W_DEF = 32;
  localparam int unsigned BYTE_W     = 8;

  localparam logic RstEnable    = 1'b0;
  localparam logic PauseDisable = 1'b0;

  typedef logic [ADDR_W_DEF-1:0] inst_addr_bus_t;
  typedef logic [INST_W_DEF-1:0] inst_bus_t;
  typedef logic [BYTE_W-1:0]     byte_bus_t;

  localparam inst_bus_t NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// PC-in, byte-memory and instruction-out bus of the fetch stage.
// misalign_o exists only when IF_MISALIGN_CHECK_EN is defined.
interface if_fetch_if #(
  parameter int unsigned ADDR_W = if_fetch_pkg::ADDR_W_DEF,
  parameter int unsigned INST_W = if_fetch_pkg::INST_W_DEF
);
  import if_fetch_pkg::*;

  logic [ADDR_W-1:0] pc_i;
  logic              pc_valid_i;
  logic              pc_ready_o;
  logic [ADDR_W-1:0] mem_a_o;
  byte_bus_t         mem_din_i;
  logic              mem_wr_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              inst_valid_o;
  logic              inst_ready_i;
`ifdef IF_MISALIGN_CHECK_EN
  logic              misalign_o;
`endif

  modport slave (
    input  pc_i, pc_valid_i, mem_din_i, inst_ready_i,
    output pc_ready_o, mem_a_o, mem_wr_o, inst_o, inst_pc_o, inst_valid_o
`ifdef IF_MISALIGN_CHECK_EN
    , misalign_o
`endif
  );

  modport master (
    output pc_i, pc_valid_i, mem_din_i, inst_ready_i,
    input  pc_ready_o, mem_a_o, mem_wr_o, inst_o, inst_pc_o, inst_valid_o
`ifdef IF_MISALIGN_CHECK_EN
    , misalign_o
`endif
  );

endinterface

// File: rtl/if_byte_assembler.sv
// Little-endian instruction assembly: load (clear or preset) the word, then
// insert each returning byte at the lane selected by the return count.
module if_byte_assembler
  import if_fetch_pkg::*;
#(
  parameter  int unsigned INST_W = INST_W_DEF,
  localparam int unsigned IDX_W  = $clog2(INST_W / BYTE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [INST_W-1:0] i_load_data,
  input  logic              i_cap,
  input  logic [IDX_W-1:0]  i_idx,
  input  byte_bus_t         i_byte,
  output logic [INST_W-1:0] o_data
);

  logic [INST_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_cap) begin
      r_data[BYTE_W*i_idx +: BYTE_W] <= i_byte;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: reads four bytes per PC from the byte-wide memory and
// hands the assembled word to IF/ID. Optional feature: IF_MISALIGN_CHECK_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush_i,
  if_fetch_if.slave   bus
);

  fetch_state_e      r_state;
  logic [1:0]        r_issue_cnt;
  logic [1:0]        r_ret_cnt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mem_a;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_inst_valid;

  logic              w_run;
  logic              w_pc_ready;
  logic              w_accept;
  logic              w_consume;
  logic              w_mis;
  logic              w_cap;
  logic [INST_W-1:0] w_load_data;
  logic [INST_W-1:0] w_inst;

  assign w_run      = (rdy != PauseDisable);
  assign w_pc_ready = !flush_i &&
                      ((r_state == IDLE) || ((r_state == HOLD) && bus.inst_ready_i));
  assign w_accept   = w_run && bus.pc_valid_i && w_pc_ready;
  assign w_consume  = w_run && !flush_i && (r_state == HOLD) && bus.inst_ready_i;

`ifdef IF_MISALIGN_CHECK_EN
  assign w_mis = (bus.pc_i[1:0] != 2'b00);
`else
  assign w_mis = 1'b0;
`endif

  // A byte is on mem_din_i whenever an address was issued in the previous cycle.
  assign w_cap = w_run && !flush_i &&
                 (((r_state == ISSUE) && (r_issue_cnt != 2'd0)) || (r_state == DRAIN));
  assign w_load_data = w_mis ? INST_W'(NOP_INST) : '0;

  if_byte_assembler #(.INST_W(INST_W)) u_asm (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_load_data (w_load_data),
    .i_cap       (w_cap),
    .i_idx       (r_ret_cnt),
    .i_byte      (bus.mem_din_i),
    .o_data      (w_inst)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state      <= IDLE;
      r_issue_cnt  <= 2'd0;
      r_ret_cnt    <= 2'd0;
      r_pc         <= '0;
      r_mem_a      <= '0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
    end else if (w_run) begin
      if (flush_i) begin
        r_state      <= IDLE;
        r_inst_valid <= 1'b0;
      end else begin
        if (w_cap) begin
          r_ret_cnt <= r_ret_cnt + 2'd1;
        end
        case (r_state)
          IDLE, HOLD: begin
            if (w_accept) begin
              r_pc         <= bus.pc_i;
              r_ret_cnt    <= 2'd0;
              r_issue_cnt  <= 2'd0;
              if (w_mis) begin
                r_state      <= HOLD;
                r_inst_pc    <= bus.pc_i;
                r_inst_valid <= 1'b1;
              end else begin
                r_state      <= ISSUE;
                r_mem_a      <= bus.pc_i;
                r_inst_valid <= 1'b0;
              end
            end else if (w_consume) begin
              r_state      <= IDLE;
              r_inst_valid <= 1'b0;
            end
          end
          ISSUE: begin
            if (r_issue_cnt == 2'd3) begin
              r_state <= DRAIN;
            end else begin
              r_mem_a     <= r_mem_a + ADDR_W'(1);
              r_issue_cnt <= r_issue_cnt + 2'd1;
            end
          end
          DRAIN: begin
            r_state      <= HOLD;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  logic r_misalign;

  // Tracks whether the held instruction is a misalignment NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_misalign <= 1'b0;
    end else if (w_run) begin
      if (flush_i) begin
        r_misalign <= 1'b0;
      end else if (w_accept) begin
        r_misalign <= w_mis;
      end else if (w_consume) begin
        r_misalign <= 1'b0;
      end
    end
  end

  assign bus.misalign_o = r_misalign;
`endif

  assign bus.pc_ready_o   = w_pc_ready;
  assign bus.mem_a_o      = r_mem_a;
  assign bus.mem_wr_o     = 1'b0;
  assign bus.inst_o       = w_inst;
  assign bus.inst_pc_o    = r_inst_pc;
  assign bus.inst_valid_o = r_inst_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: vector table of single fetches plus
// hand-written backpressure, pause, flush, wrap/misalign and async-reset cases.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic rdy     = 1'b1;
  logic flush_i = 1'b0;

  if_fetch_if bus ();

  if_fetch u_dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .flush_i (flush_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100: mem_rd = 8'h13;  32'h101: mem_rd = 8'h05;
      32'h102: mem_rd = 8'h00;  32'h103: mem_rd = 8'h00;
      32'h104: mem_rd = 8'h93;  32'h105: mem_rd = 8'h05;
      32'h106: mem_rd = 8'h10;  32'h107: mem_rd = 8'h00;
      32'h200: mem_rd = 8'h11;  32'h201: mem_rd = 8'h22;
      32'h202: mem_rd = 8'h33;  32'h203: mem_rd = 8'h44;
      32'h300: mem_rd = 8'hb3;  32'h301: mem_rd = 8'h86;
      32'h302: mem_rd = 8'hc5;  32'h303: mem_rd = 8'h00;
      32'h040: mem_rd = 8'hef;  32'h041: mem_rd = 8'hbe;
      32'h042: mem_rd = 8'had;  32'h043: mem_rd = 8'hde;
      32'hFFFF_FFFE: mem_rd = 8'h37;  32'hFFFF_FFFF: mem_rd = 8'h12;
      32'h000: mem_rd = 8'h34;  32'h001: mem_rd = 8'hab;
      default: mem_rd = a[7:0] ^ 8'h5a;
    endcase
  endfunction

  // Byte memory with one-cycle read latency that honours rdy.
  always @(posedge clk) begin
    if (rdy) bus.mem_din_i <= mem_rd(bus.mem_a_o);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Present a PC at a negedge; the handshake completes on the next posedge.
  task automatic start(input logic [31:0] pc);
    bus.pc_i       = pc;
    bus.pc_valid_i = 1'b1;
    #1;
    chk("pc_ready_at_start", 32'(bus.pc_ready_o), 32'd1);
  endtask

  // Cycles 1..6 after the handshake edge, then `hold` backpressured cycles.
  task automatic body(input logic [31:0] pc, input logic [31:0] exp, input int hold);
    @(negedge clk);
    bus.pc_valid_i   = 1'b0;
    bus.inst_ready_i = 1'b0;
    chk("mem_a_cyc1", bus.mem_a_o, pc);
    chk("valid_cyc1", 32'(bus.inst_valid_o), 32'd0);
    chk("mem_wr", 32'(bus.mem_wr_o), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("mem_a_issue", bus.mem_a_o, pc + 32'(k));
      chk("valid_issue", 32'(bus.inst_valid_o), 32'd0);
    end
    @(negedge clk);
    chk("valid_cyc5", 32'(bus.inst_valid_o), 32'd0);
    @(negedge clk);
    chk("valid_cyc6", 32'(bus.inst_valid_o), 32'd1);
    chk("inst_cyc6", bus.inst_o, exp);
    chk("inst_pc_cyc6", bus.inst_pc_o, pc);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.inst_valid_o), 32'd1);
      chk("hold_inst", bus.inst_o, exp);
      chk("hold_pc", bus.inst_pc_o, pc);
      chk("hold_pc_ready", 32'(bus.pc_ready_o), 32'd0);
    end
  endtask

  task automatic consume();
    bus.inst_ready_i = 1'b1;
    #1;
    chk("pc_ready_consume", 32'(bus.pc_ready_o), 32'd1);
    @(negedge clk);
    bus.inst_ready_i = 1'b0;
    #1;
    chk("valid_after_consume", 32'(bus.inst_valid_o), 32'd0);
    chk("pc_ready_idle", 32'(bus.pc_ready_o), 32'd1);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] mem_a_before;

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h0000_0513, 0};
    vecs[1] = '{32'h0000_0104, 32'h0010_0593, 2};
    vecs[2] = '{32'h0000_0300, 32'h00c5_86b3, 1};
    vecs[3] = '{32'h0000_0040, 32'hdead_beef, 0};

    bus.pc_i         = '0;
    bus.pc_valid_i   = 1'b0;
    bus.inst_ready_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_a", bus.mem_a_o, 32'd0);
    chk("rst_inst", bus.inst_o, 32'd0);
    chk("rst_inst_pc", bus.inst_pc_o, 32'd0);
    chk("rst_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("rst_mem_wr", 32'(bus.mem_wr_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("pc_ready_after_rst", 32'(bus.pc_ready_o), 32'd1);

    for (int i = 0; i < 4; i++) begin
      start(vecs[i].pc);
      body(vecs[i].pc, vecs[i].exp, vecs[i].hold);
      consume();
    end

    // Backpressure then consume-and-accept on the same edge
    start(32'h100);
    body(32'h100, 32'h0000_0513, 3);
    bus.inst_ready_i = 1'b1;
    start(32'h104);
    body(32'h104, 32'h0010_0593, 0);
    consume();

    // Pause for 4 cycles while the third address is on the bus
    start(32'h200);
    @(negedge clk);
    bus.pc_valid_i = 1'b0;
    chk("pause_a0", bus.mem_a_o, 32'h200);
    @(negedge clk);
    chk("pause_a1", bus.mem_a_o, 32'h201);
    @(negedge clk);
    chk("pause_a2", bus.mem_a_o, 32'h202);
    rdy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("pause_frozen_a", bus.mem_a_o, 32'h202);
      chk("pause_frozen_valid", 32'(bus.inst_valid_o), 32'd0);
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("pause_a3", bus.mem_a_o, 32'h203);
    @(negedge clk);
    chk("pause_valid_cyc5", 32'(bus.inst_valid_o), 32'd0);
    @(negedge clk);
    chk("pause_valid", 32'(bus.inst_valid_o), 32'd1);
    chk("pause_inst", bus.inst_o, 32'h4433_2211);
    chk("pause_inst_pc", bus.inst_pc_o, 32'h200);
    rdy = 1'b0;
    bus.inst_ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("pause_no_consume", 32'(bus.inst_valid_o), 32'd1);
    end
    rdy = 1'b1;
    @(negedge clk);
    bus.inst_ready_i = 1'b0;
    chk("pause_consumed", 32'(bus.inst_valid_o), 32'd0);

    // Flush mid-fetch; next PC accepted the following cycle
    start(32'h200);
    @(negedge clk);
    bus.pc_valid_i = 1'b0;
    chk("flush_a0", bus.mem_a_o, 32'h200);
    @(negedge clk);
    chk("flush_a1", bus.mem_a_o, 32'h201);
    @(negedge clk);
    flush_i        = 1'b1;
    bus.pc_i       = 32'h300;
    bus.pc_valid_i = 1'b1;
    #1;
    chk("flush_pc_ready", 32'(bus.pc_ready_o), 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("flush_then_ready", 32'(bus.pc_ready_o), 32'd1);
    body(32'h300, 32'h00c5_86b3, 0);
    consume();

    // Flush while holding an instruction
    start(32'h100);
    body(32'h100, 32'h0000_0513, 1);
    flush_i = 1'b1;
    #1;
    chk("flush_hold_pc_ready", 32'(bus.pc_ready_o), 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_hold_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("flush_hold_ready", 32'(bus.pc_ready_o), 32'd1);

    // Address wrap / misaligned PC
`ifdef IF_MISALIGN_CHECK_EN
    mem_a_before = bus.mem_a_o;
    start(32'hFFFF_FFFE);
    @(negedge clk);
    bus.pc_valid_i = 1'b0;
    chk("mis_valid", 32'(bus.inst_valid_o), 32'd1);
    chk("mis_flag", 32'(bus.misalign_o), 32'd1);
    chk("mis_inst", bus.inst_o, 32'h0000_0013);
    chk("mis_inst_pc", bus.inst_pc_o, 32'hFFFF_FFFE);
    chk("mis_no_mem", bus.mem_a_o, mem_a_before);
    consume();
    chk("mis_flag_clear", 32'(bus.misalign_o), 32'd0);
    chk("mis_still_no_mem", bus.mem_a_o, mem_a_before);
`else
    mem_a_before = 32'hFFFF_FFFE;
    start(mem_a_before);
    body(mem_a_before, 32'hab34_1237, 0);
    consume();
`endif

    // Async reset between edges while the last byte is draining
    start(32'h104);
    @(negedge clk);
    bus.pc_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_mem_a", bus.mem_a_o, 32'h107);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_mem_a", bus.mem_a_o, 32'd0);
    chk("async_rst_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("async_rst_inst", bus.inst_o, 32'd0);
    chk("async_rst_inst_pc", bus.inst_pc_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("pc_ready_after_async_rst", 32'(bus.pc_ready_o), 32'd1);
    start(32'h40);
    body(32'h40, 32'hdead_beef, 0);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Accepts a 32-bit PC through a valid/ready handshake and reads four bytes from the byte-wide unified memory port.
- Assembles the bytes little-endian into one 32-bit instruction and presents it, with its PC, to the IF/ID latch through a second valid/ready handshake.
- Supports a flush from later stages and the global `rdy` pause.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INST_W, 32, instruction width; fixed at 4 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- rdy  in  1  global pause; 0 freezes every register in this block.
- pc_i  in  ADDR_W  PC to fetch.
- pc_valid_i  in  1  pc_i is valid.
- pc_ready_o  out  1  block accepts pc_i this cycle.
- flush_i  in  1  discard the in-flight fetch and any held instruction.
- mem_a_o  out  ADDR_W  byte address to memory (registered).
- mem_din_i  in  8  read byte; returns the byte addressed in the previous cycle.
- mem_wr_o  out  1  always 0 (read only).
- inst_o  out  INST_W  assembled instruction.
- inst_pc_o  out  ADDR_W  PC of inst_o.
- inst_valid_o  out  1  inst_o/inst_pc_o are valid.
- inst_ready_i  in  1  IF/ID consumes the instruction this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; mem_a_o=0; inst_o=0; inst_pc_o=0; inst_valid_o=0; byte counters=0.
  - pc_ready_o=1 in the first cycle after reset release.
- States:
  - IDLE → ISSUE on a handshake (pc_valid_i & pc_ready_o at a clock edge).
  - ISSUE (issue cnt 0..3) → DRAIN after address 3 is issued.
  - DRAIN (last byte returns) → HOLD.
  - HOLD → IDLE when inst_ready_i=1.
- Handshake edge E0:
  - Latch pc_i; mem_a_o ← pc_i.
  - mem_a_o = pc, pc+1, pc+2, pc+3 in cycles 1..4; addresses wrap modulo 2^ADDR_W.
  - Byte k is on mem_din_i in cycle k+2 and is captured into inst bits [8k+7:8k].
  - inst_valid_o=1 from cycle 6 (latency 5 edges after E0).
- pc_ready_o (combinational):
  - 1 in IDLE.
  - 1 in HOLD when inst_ready_i=1 (back-to-back: consume and accept on the same edge; the next fetch starts without an IDLE bubble).
  - 0 otherwise.
- HOLD:
  - inst_o/inst_pc_o remain stable while inst_valid_o=1 and inst_ready_i=0.
  - inst_valid_o drops on the consuming edge unless a new instruction completes on that same edge (cannot occur; latency ≥5).
- flush_i=1 at an edge (with rdy=1):
  - state → IDLE; inst_valid_o → 0; bytes still in flight are ignored.
  - pc_ready_o is 0 during the flush cycle; a pc_valid_i in the same cycle is not accepted.
  - flush has priority over every other event.
- rdy=0:
  - All state, counters and outputs hold; no handshake completes even if pc_valid_i/inst_ready_i are high.
  - The memory honours the same rdy, so the byte for the last address issued returns in the first cycle with rdy=1.
  - Reset overrides rdy.
- mem_wr_o is tied to 0 at all times.

Optional Feature:
- Macro: IF_MISALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_o (1 bit).
  - A PC with pc_i[1:0]≠0 is accepted, but no memory read is issued.
  - Goes IDLE→HOLD after one edge with inst_o=32'h00000013 (NOP), inst_pc_o=pc, inst_valid_o=1, misalign_o=1.
  - misalign_o clears together with inst_valid_o; reset value 0.
- Undefined:
  - Port is absent; low PC bits are ignored and any byte address is fetched normally.

Decomposition:
- Shared defines header: RstEnable (1'b0 for this block's active-low reset), PauseDisable, InstAddrBus, InstBus, ByteBus, NOP encoding 32'h00000013, fetch state encodings (IDLE/ISSUE/DRAIN/HOLD).
- One natural sub-module, if_byte_assembler: shift/insert register indexed by return count with load-clear; the FSM and address counter stay in if_fetch.

Test Plan:
- Single fetch: memory bytes at 0x100..0x103 = 13,05,00,00; pc_i=0x100 handshake → mem_a_o 0x100..0x103 in cycles 1–4; inst_o=0x00000513, inst_pc_o=0x100, inst_valid_o=1 in cycle 6.
- Backpressure then back-to-back: inst_ready_i=0 for 3 cycles → outputs stable, pc_ready_o=0; then inst_ready_i=1 with pc_valid_i=1, pc_i=0x104 → consume and accept on the same edge; next instruction valid 5 edges later.
- Pause: rdy=0 for 4 cycles during issue cnt 2 → mem_a_o frozen at pc+2; result identical to the no-pause case, delayed exactly 4 cycles.
- Flush: flush_i=1 at cycle 3 of a fetch of 0x200 → inst_valid_o stays 0; a new fetch of 0x300 accepted on the next cycle returns only the bytes at 0x300.
- Async reset: rst=0 mid-DRAIN between clock edges → inst_valid_o=0, mem_a_o=0 immediately; after release, pc_ready_o=1.
- Wrap/misalign: pc_i=0xFFFFFFFE → addresses FFFFFFFE, FFFFFFFF, 0, 1. With IF_MISALIGN_CHECK_EN defined, the same PC instead gives misalign_o=1, inst_o=0x13, and no memory addresses issued.
